// File: rtl/hd63701_irq2_arb.sv
// hd63701_irq2_arb
// Fixed-priority arbiter for the on-chip IRQ2 sources (ICI > OCI > TOI > SCI).
// Turns level-type peripheral flags into one clean IRQ2 rising edge per
// service, holds a stable vector nibble until the core's vector fetch (VACK),
// then forces a low gap so a still-pending flag produces a fresh edge.
// All outputs are registered; nothing combinational reaches an output pin.

module hd63701_irq2_arb #(
  parameter int          GAP_CYC = 1,     // IRQ2-low cycles after each service (>=1)
  parameter int          TMO_CYC = 0,     // HOLD cycles before abandoning; 0 = never
  parameter logic [3:0]  V_ICI   = 4'h6,
  parameter logic [3:0]  V_OCI   = 4'h4,
  parameter logic [3:0]  V_TOI   = 4'h2,
  parameter logic [3:0]  V_SCI   = 4'h0
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [3:0] SRC_REQ,
  input  logic [3:0] SRC_EN,
  input  logic       VACK,
  output logic       IRQ2,
  output logic [3:0] IRQ2V,
  output logic [3:0] ISRV,
  output logic       SPUR,
  output logic       BUSY
);

  // Counter widths; a zero-width counter is not legal, so clamp to one bit.
  localparam int GW = (GAP_CYC < 1) ? 1 : $clog2(GAP_CYC + 1);
  localparam int TW = (TMO_CYC < 1) ? 1 : $clog2(TMO_CYC + 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYC < 1) ? '0 : GW'(GAP_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST = (TMO_CYC < 1) ? '0 : TW'(TMO_CYC - 1);
  localparam bit            TMO_ON   = (TMO_CYC != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_HOLD  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t          state;
  logic [1:0]      gsel;
  logic [GW-1:0]   gap_cnt;
  logic [TW-1:0]   tmo_cnt;

  logic [3:0]      act;
  logic [1:0]      win_idx;
  logic [3:0]      win_vec;

  assign act = SRC_REQ & SRC_EN;

  // Priority encode the enabled flags and map the winner to its vector nibble.
  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    win_idx = 2'd0;
    if (act[3])      win_idx = 2'd3;
    else if (act[2]) win_idx = 2'd2;
    else if (act[1]) win_idx = 2'd1;
    else             win_idx = 2'd0;

    win_vec = V_SCI;
    case (win_idx)
      2'd3:    win_vec = V_ICI;
      2'd2:    win_vec = V_OCI;
      2'd1:    win_vec = V_TOI;
      default: win_vec = V_SCI;
    endcase
  end

  // Arbitration FSM with registered outputs; pulses default low each cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= S_IDLE;
      gsel    <= 2'd0;
      gap_cnt <= '0;
      tmo_cnt <= '0;
      IRQ2    <= 1'b0;
      IRQ2V   <= 4'h0;
      ISRV    <= 4'h0;
      SPUR    <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      ISRV <= 4'h0;
      SPUR <= 1'b0;

      case (state)
        S_IDLE: begin
          if (VACK) SPUR <= 1'b1;
          if (act != 4'h0) begin
            state <= S_GRANT;
            BUSY  <= 1'b1;
          end
        end

        S_GRANT: begin
          if (VACK) SPUR <= 1'b1;
          if (act != 4'h0) begin
            // Winner is chosen here and frozen for the whole service.
            gsel    <= win_idx;
            IRQ2V   <= win_vec;
            IRQ2    <= 1'b1;
            tmo_cnt <= '0;
            state   <= S_HOLD;
          end else begin
            // Request vanished before the edge was issued: nothing to serve.
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end
        end

        S_HOLD: begin
          if (VACK) begin
            // Acknowledge beats a simultaneous timeout.
            ISRV    <= 4'b0001 << gsel;
            IRQ2    <= 1'b0;
            gap_cnt <= '0;
            state   <= S_GAP;
          end else if (TMO_ON && (tmo_cnt == TMO_LAST)) begin
            SPUR    <= 1'b1;
            IRQ2    <= 1'b0;
            gap_cnt <= '0;
            state   <= S_GAP;
          end else if (tmo_cnt != TMO_LAST) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (VACK) SPUR <= 1'b1;
          if (gap_cnt == GAP_LAST) begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          IRQ2  <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hd63701_irq2_arb.sv
// Directed bench for hd63701_irq2_arb built with GAP_CYC=2, TMO_CYC=8.
// Inputs change 1ns after a rising edge; outputs are sampled at that same
// point, i.e. away from the active edge.

module tb_hd63701_irq2_arb;

  localparam int GAP = 2;
  localparam int TMO = 8;

  logic       CLK;
  logic       RSTn;
  logic [3:0] SRC_REQ;
  logic [3:0] SRC_EN;
  logic       VACK;
  logic       IRQ2;
  logic [3:0] IRQ2V;
  logic [3:0] ISRV;
  logic       SPUR;
  logic       BUSY;

  int checks = 0;
  int errors = 0;

  hd63701_irq2_arb #(
    .GAP_CYC(GAP),
    .TMO_CYC(TMO)
  ) dut (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .SRC_REQ(SRC_REQ),
    .SRC_EN (SRC_EN),
    .VACK   (VACK),
    .IRQ2   (IRQ2),
    .IRQ2V  (IRQ2V),
    .ISRV   (ISRV),
    .SPUR   (SPUR),
    .BUSY   (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle VACK pulse; outputs afterwards reflect the acknowledging edge.
  task automatic ack();
    VACK = 1'b1;
    tick();
    VACK = 1'b0;
  endtask

  initial begin
    RSTn    = 1'b0;
    SRC_REQ = 4'hF;
    SRC_EN  = 4'hF;
    VACK    = 1'b0;

    // 1: reset with everything requesting
    ticks(2);
    check("rst_irq2", {3'b0, IRQ2}, 4'h0);
    check("rst_irq2v", IRQ2V, 4'h0);
    check("rst_busy", {3'b0, BUSY}, 4'h0);
    check("rst_isrv", ISRV, 4'h0);
    check("rst_spur", {3'b0, SPUR}, 4'h0);
    RSTn = 1'b1;
    tick();
    check("lat1_irq2", {3'b0, IRQ2}, 4'h0);
    check("lat1_busy", {3'b0, BUSY}, 4'h1);
    tick();
    check("lat2_irq2", {3'b0, IRQ2}, 4'h1);
    check("lat2_irq2v", IRQ2V, 4'h6);
    ack();
    check("ici_isrv", ISRV, 4'b1000);
    check("ici_irq2_low", {3'b0, IRQ2}, 4'h0);
    SRC_REQ = 4'h0;
    ticks(3);
    check("ici_idle_busy", {3'b0, BUSY}, 4'h0);

    // 2: priority TOI over SCI, re-arm while still pending
    SRC_REQ = 4'b0011;
    ticks(2);
    check("pri_irq2", {3'b0, IRQ2}, 4'h1);
    check("pri_irq2v", IRQ2V, 4'h2);
    ack();
    check("pri_isrv", ISRV, 4'b0010);
    check("pri_gap0", {3'b0, IRQ2}, 4'h0);
    tick();
    check("pri_isrv_pulse", ISRV, 4'h0);
    check("pri_gap1", {3'b0, IRQ2}, 4'h0);
    tick();
    check("pri_gap2", {3'b0, IRQ2}, 4'h0);
    tick();
    check("pri_gap3", {3'b0, IRQ2}, 4'h0);
    tick();
    check("pri_rearm_irq2", {3'b0, IRQ2}, 4'h1);
    check("pri_rearm_irq2v", IRQ2V, 4'h2);
    ack();
    check("pri_isrv2", ISRV, 4'b0010);
    SRC_REQ = 4'h0;
    ticks(3);
    check("pri_idle_busy", {3'b0, BUSY}, 4'h0);

    // 3: masking, enable widened during HOLD does not change the vector
    SRC_REQ = 4'b1001;
    SRC_EN  = 4'b0001;
    ticks(2);
    check("mask_irq2", {3'b0, IRQ2}, 4'h1);
    check("mask_irq2v", IRQ2V, 4'h0);
    SRC_EN = 4'hF;
    ticks(3);
    check("mask_hold_irq2v", IRQ2V, 4'h0);
    check("mask_hold_irq2", {3'b0, IRQ2}, 4'h1);
    ack();
    check("mask_isrv", ISRV, 4'b0001);
    ticks(4);
    check("mask_next_irq2", {3'b0, IRQ2}, 4'h1);
    check("mask_next_irq2v", IRQ2V, 4'h6);
    ack();
    check("mask_next_isrv", ISRV, 4'b1000);
    SRC_REQ = 4'h0;
    ticks(3);

    // 4: a higher source arriving during HOLD does not preempt
    SRC_REQ = 4'b0001;
    ticks(2);
    check("pre_irq2v", IRQ2V, 4'h0);
    SRC_REQ = 4'b1001;
    ticks(2);
    check("pre_hold_irq2v", IRQ2V, 4'h0);
    check("pre_hold_irq2", {3'b0, IRQ2}, 4'h1);
    ack();
    check("pre_isrv", ISRV, 4'b0001);
    ticks(4);
    check("pre_next_irq2v", IRQ2V, 4'h6);
    check("pre_next_irq2", {3'b0, IRQ2}, 4'h1);
    ack();
    SRC_REQ = 4'h0;
    ticks(3);
    check("pre_idle_busy", {3'b0, BUSY}, 4'h0);

    // 5: timeout after 8 HOLD cycles, then re-request
    SRC_REQ = 4'b0100;
    ticks(2);
    check("tmo_irq2_on", {3'b0, IRQ2}, 4'h1);
    check("tmo_irq2v", IRQ2V, 4'h4);
    ticks(TMO - 1);
    check("tmo_irq2_last", {3'b0, IRQ2}, 4'h1);
    check("tmo_spur_early", {3'b0, SPUR}, 4'h0);
    tick();
    check("tmo_irq2_off", {3'b0, IRQ2}, 4'h0);
    check("tmo_spur", {3'b0, SPUR}, 4'h1);
    check("tmo_isrv", ISRV, 4'h0);
    tick();
    check("tmo_spur_pulse", {3'b0, SPUR}, 4'h0);
    check("tmo_gap_irq2", {3'b0, IRQ2}, 4'h0);
    ticks(3);
    check("tmo_rearm_irq2", {3'b0, IRQ2}, 4'h1);
    check("tmo_rearm_irq2v", IRQ2V, 4'h4);

    // 6b: VACK on the timeout-expiry cycle -> ISRV only
    ticks(TMO - 1);
    check("tie_irq2", {3'b0, IRQ2}, 4'h1);
    ack();
    check("tie_isrv", ISRV, 4'b0100);
    check("tie_spur", {3'b0, SPUR}, 4'h0);
    SRC_REQ = 4'h0;
    ticks(3);
    check("tie_idle_busy", {3'b0, BUSY}, 4'h0);

    // 6a: stray VACK in IDLE
    ack();
    check("stray_spur", {3'b0, SPUR}, 4'h1);
    check("stray_isrv", ISRV, 4'h0);
    check("stray_busy", {3'b0, BUSY}, 4'h0);
    tick();
    check("stray_spur_pulse", {3'b0, SPUR}, 4'h0);

    // Reset asserted mid-HOLD drops IRQ2 without waiting for a clock
    SRC_REQ = 4'b0010;
    ticks(2);
    check("arst_pre_irq2", {3'b0, IRQ2}, 4'h1);
    #1;
    RSTn = 1'b0;
    #1;
    check("arst_irq2", {3'b0, IRQ2}, 4'h0);
    check("arst_busy", {3'b0, BUSY}, 4'h0);
    check("arst_isrv", ISRV, 4'h0);
    check("arst_spur", {3'b0, SPUR}, 4'h0);
    tick();
    RSTn = 1'b1;
    ticks(2);
    check("arst_rearm_irq2v", IRQ2V, 4'h2);
    check("arst_rearm_irq2", {3'b0, IRQ2}, 4'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
